cr_axi4s_mst: RTL and testbench

//  AXI4-Stream transmit buffer: the master-side counterpart of the inbound AXI4-S slave FIFO.

---
 rtl/cr_axi4s_mst.sv | 145 ++++++++++++++
 tb/tb_cr_axi4s_mst.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cr_axi4s_mst.sv
// AXI4-Stream transmit buffer: core-side write port feeding a registered, fully
// backpressured outbound AXI4-S master, with optional store-and-forward per packet.
package cr_axi4s_pkg;
  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [3:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;
endpackage

module cr_axi4s_mst
  import cr_axi4s_pkg::*;
#(
  parameter int N_ENTRIES    = 16,
  parameter int N_AFULL_VAL  = 1,
  parameter int N_AEMPTY_VAL = 1,
  parameter int STORE_FWD    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          axi4s_mst_wr,
  input  axi4s_dp_bus_t axi4s_mst_in,
  output logic          axi4s_mst_full,
  output logic          axi4s_mst_afull,
  output logic          axi4s_mst_empty,
  output logic          axi4s_mst_aempty,
  output logic          axi4s_mst_ovfl,
  output axi4s_dp_bus_t axi4s_ob_out,
  input  axi4s_dp_rdy_t axi4s_ob_in
);

  localparam int N_DATA_BITS = $bits(axi4s_dp_bus_t);
  localparam int CNT_W       = $clog2(N_ENTRIES + 1);
  localparam int N_ARR       = N_ENTRIES - 1;
  localparam int PTR_W       = (N_ARR > 1) ? $clog2(N_ARR) : 1;

  typedef enum logic {PKT_IDLE, PKT_BODY} pkt_state_e;

  logic [N_DATA_BITS-1:0] mem [N_ARR];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count, count_nxt, held, pkt_cnt, pkt_cnt_nxt;
  axi4s_dp_bus_t          ob_q, beat_in, load_beat;
  pkt_state_e             pkt_state, pkt_state_nxt;
  logic                   wr_acc, hs, arr_empty, src_avail, rel, load, in_pkt;
  logic                   full_q, afull_q, empty_q, aempty_q, ovfl_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_ARR - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_acc      = axi4s_mst_wr & ~full_q;
    hs          = ob_q.tvalid & axi4s_ob_in.tready;
    arr_empty   = (count == CNT_W'(ob_q.tvalid));
    src_avail   = ~arr_empty | wr_acc;
    held        = count + CNT_W'(wr_acc);
    count_nxt   = held - CNT_W'(hs);
    pkt_cnt_nxt = pkt_cnt + CNT_W'(wr_acc & axi4s_mst_in.tlast) - CNT_W'(hs & ob_q.tlast);
    // Release looks at this cycle's write and handshake so a completing tlast
    // starts the packet next clk, and an array that would overflow forwards at full.
    if (STORE_FWD != 0) begin
      rel = (pkt_cnt_nxt != '0) | in_pkt | (held == CNT_W'(N_ENTRIES));
    end else begin
      rel = 1'b1;
    end
    load           = (~ob_q.tvalid | axi4s_ob_in.tready) & src_avail & rel;
    beat_in        = axi4s_mst_in;
    beat_in.tvalid = 1'b1;
    load_beat      = arr_empty ? beat_in : axi4s_dp_bus_t'(mem[rd_ptr]);
  end

  always_ff @(posedge clk) begin
    if (wr_acc & ~(load & arr_empty)) begin
      mem[wr_ptr] <= beat_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pkt_cnt  <= '0;
      ob_q     <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovfl_q   <= 1'b0;
    end else begin
      count   <= count_nxt;
      pkt_cnt <= pkt_cnt_nxt;
      if (wr_acc & ~(load & arr_empty)) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (load & ~arr_empty) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (load) begin
        ob_q <= load_beat;
      end else if (hs) begin
        ob_q <= '0;
      end
      full_q   <= (count_nxt == CNT_W'(N_ENTRIES));
      afull_q  <= (count_nxt >= CNT_W'(N_ENTRIES - N_AFULL_VAL));
      empty_q  <= (count_nxt == '0);
      aempty_q <= (count_nxt <= CNT_W'(N_AEMPTY_VAL));
      if (axi4s_mst_wr & full_q) begin
        ovfl_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_state <= PKT_IDLE;
    end else begin
      pkt_state <= pkt_state_nxt;
    end
  end

  always_comb begin
    pkt_state_nxt = pkt_state;
    if (load) begin
      pkt_state_nxt = load_beat.tlast ? PKT_IDLE : PKT_BODY;
    end
  end

  always_comb begin
    in_pkt = (pkt_state == PKT_BODY);
  end

  assign axi4s_mst_full   = full_q;
  assign axi4s_mst_afull  = afull_q;
  assign axi4s_mst_empty  = empty_q;
  assign axi4s_mst_aempty = aempty_q;
  assign axi4s_mst_ovfl   = ovfl_q;
  assign axi4s_ob_out     = ob_q;

endmodule

// File: tb/tb_cr_axi4s_mst.sv
// Bench for cr_axi4s_mst: cut-through and store-and-forward instances driven in
// lockstep, each compared against a queue model of beats held.
module tb_cr_axi4s_mst;
  import cr_axi4s_pkg::*;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  axi4s_dp_bus_t din = '0;
  axi4s_dp_rdy_t rdy = '0;
  axi4s_dp_bus_t ob [2];
  logic          full [2], afull [2], empty [2], aempty [2], ovfl [2];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cr_axi4s_mst #(.N_ENTRIES(N), .N_AFULL_VAL(1), .N_AEMPTY_VAL(1), .STORE_FWD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .axi4s_mst_wr(wr), .axi4s_mst_in(din),
    .axi4s_mst_full(full[0]), .axi4s_mst_afull(afull[0]), .axi4s_mst_empty(empty[0]),
    .axi4s_mst_aempty(aempty[0]), .axi4s_mst_ovfl(ovfl[0]),
    .axi4s_ob_out(ob[0]), .axi4s_ob_in(rdy)
  );

  cr_axi4s_mst #(.N_ENTRIES(N), .N_AFULL_VAL(1), .N_AEMPTY_VAL(1), .STORE_FWD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .axi4s_mst_wr(wr), .axi4s_mst_in(din),
    .axi4s_mst_full(full[1]), .axi4s_mst_afull(afull[1]), .axi4s_mst_empty(empty[1]),
    .axi4s_mst_aempty(aempty[1]), .axi4s_mst_ovfl(ovfl[1]),
    .axi4s_ob_out(ob[1]), .axi4s_ob_in(rdy)
  );

  // Model: FIFO of beats held per instance; index 1 is store-and-forward.
  axi4s_dp_bus_t mm [2][N];
  int unsigned   hd [2];
  int unsigned   sz [2];
  bit            m_inpkt [2];
  bit            m_ovfl [2];
  bit            m_rst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_vis(input int d);
    bit has_last = 1'b0;
    if (sz[d] == 0) return 1'b0;
    if (d == 0) return 1'b1;
    for (int unsigned i = 0; i < sz[d]; i++)
      if (mm[d][(hd[d] + i) % N].tlast) has_last = 1'b1;
    return has_last || m_inpkt[d] || (sz[d] == N);
  endfunction

  task automatic compare(input int d);
    bit v;
    axi4s_dp_bus_t e;
    string p;
    v = m_vis(d);
    e = mm[d][hd[d]];
    p = $sformatf("sf%0d", d);
    check({p, " tvalid"}, 64'(ob[d].tvalid), 64'(v));
    if (v) begin
      check({p, " tdata"}, ob[d].tdata, e.tdata);
      check({p, " tlast"}, 64'(ob[d].tlast), 64'(e.tlast));
      check({p, " tuser"}, 64'(ob[d].tuser), 64'(e.tuser));
    end
    if (m_rst) check({p, " ob_zero"}, 64'(ob[d] == '0), 64'd1);
    check({p, " full"},   64'(full[d]),   64'(sz[d] == N));
    check({p, " afull"},  64'(afull[d]),  64'(sz[d] >= N - 1));
    check({p, " empty"},  64'(empty[d]),  64'(sz[d] == 0));
    check({p, " aempty"}, 64'(aempty[d]), 64'(sz[d] <= 1));
    check({p, " ovfl"},   64'(ovfl[d]),   64'(m_ovfl[d]));
  endtask

  task automatic step(input bit w, input logic [63:0] data, input bit last, input bit r);
    axi4s_dp_bus_t b;
    bit pv [2];
    bit hs;
    b        = '0;
    b.tdata  = data;
    b.tlast  = last;
    b.tuser  = data[3:0] ^ 4'h9;
    b.tvalid = 1'($urandom_range(1));
    @(negedge clk);
    wr         = w;
    din        = b;
    rdy.tready = r;
    for (int d = 0; d < 2; d++) pv[d] = m_vis(d);
    @(posedge clk);
    m_rst = !rst_n;
    for (int d = 0; d < 2; d++) begin
      if (m_rst) begin
        hd[d] = 0; sz[d] = 0; m_inpkt[d] = 1'b0; m_ovfl[d] = 1'b0;
      end else begin
        hs = pv[d] && r;
        if (w && sz[d] == N) m_ovfl[d] = 1'b1;
        if (hs) begin
          m_inpkt[d] = !mm[d][hd[d]].tlast;
          hd[d] = (hd[d] + 1) % N;
          sz[d]--;
        end
        // Full is judged from the count before this edge, so a freed slot is not reused.
        if (w && (sz[d] + (hs ? 1 : 0)) != N) begin
          mm[d][(hd[d] + sz[d]) % N] = b;
          mm[d][(hd[d] + sz[d]) % N].tvalid = 1'b1;
          sz[d]++;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) compare(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 64'd0, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    int unsigned cyc;
    bit          w;
    for (int d = 0; d < 2; d++) begin
      hd[d] = 0; sz[d] = 0; m_inpkt[d] = 1'b0; m_ovfl[d] = 1'b0;
    end
    m_rst = 1'b0;

    // Single beat, cut-through latency and handshake.
    do_reset();
    step(1'b1, 64'hA5, 1'b1, 1'b1);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b0, 1'b1);

    // Fill under backpressure, then overflow.
    for (int i = 0; i < N; i++) step(1'b1, 64'(i), (i == N - 1), 1'b0);
    step(1'b1, 64'hDEAD, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0);

    // Write while full with a handshake in the same clk, then drain across pointer wrap.
    step(1'b1, 64'd99, 1'b1, 1'b1);
    for (int i = 0; i < N + 2; i++) step(1'b0, 64'd0, 1'b0, 1'b1);

    // Random traffic and backpressure.
    do_reset();
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 6000) begin
      w = 1'($urandom_range(1));
      if (w && sz[0] != N) acc++;
      step(w, {$urandom, $urandom}, ($urandom_range(3) == 0), 1'($urandom_range(1)));
      cyc++;
    end
    check("random_beats_accepted", 64'(acc), 64'd1000);
    for (int i = 0; i < 2 * N; i++) step(1'b0, 64'd0, 1'b0, 1'b1);
    step(1'b1, 64'h77, 1'b1, 1'b1);
    for (int i = 0; i < 2 * N; i++) step(1'b0, 64'd0, 1'b0, 1'b1);

    // Store-and-forward: short packet held until tlast, then oversize packet.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 64'(16'h100 + i), 1'b0, 1'b1);
    step(1'b1, 64'h103, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b1, 64'(16'h200 + i), (i == 23), 1'b1);
    for (int i = 0; i < 2 * N; i++) step(1'b0, 64'd0, 1'b0, 1'b1);

    // Reset with a partial packet buffered, then a fresh packet.
    for (int i = 0; i < 5; i++) step(1'b1, 64'(16'h300 + i), 1'b0, 1'b0);
    step(1'b1, 64'h3FF, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 64'hBAD, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 64'(16'h400 + i), (i == 2), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
